// File: rtl/manchester_pkg.sv
`default_nettype none
// ============================================================================
// Module   : manchester_pkg
// Brief    : Shared mode constants, tx state type and half-symbol level helper
// Revision : 1.0 - initial release
// ============================================================================
package manchester_pkg;

    localparam logic MODE_IEEE   = 1'b0;
    localparam logic MODE_THOMAS = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } tx_state_t;

    // IEEE leads with the complement of the bit, Thomas leads with the bit.
    function automatic logic manch_half(input logic bit_val, input logic mode, input logic phase);
        return (mode == MODE_THOMAS) ? (bit_val ^ phase) : (bit_val ^ ~phase);
    endfunction

endpackage
`default_nettype wire

// File: rtl/manchester_half_timer.sv
`default_nettype none
// ============================================================================
// Module   : manchester_half_timer
// Brief    : Half-symbol pacing counter with end-of-half strobe and phase bit
// Revision : 1.0 - initial release
// ============================================================================
module manchester_half_timer #(
    parameter int HALF_BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic half_end,
    output logic phase
);

    localparam int c_CNT_W = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(HALF_BIT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_phase;

    assign half_end = run & (r_cnt == c_LAST);
    assign phase    = r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (clear) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (run) begin
            if (r_cnt == c_LAST) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/manchester_tx_serial.sv
`default_nettype none
// ============================================================================
// Module   : manchester_tx_serial
// Brief    : Serial Manchester line encoder with optional alternating preamble
// Revision : 1.0 - initial release
// ============================================================================
module manchester_tx_serial
    import manchester_pkg::*;
#(
    parameter int   DATA_W          = 8,
    parameter int   HALF_BIT_CYCLES = 4,
    parameter int   PREAMBLE_BITS   = 0,
    parameter bit   MSB_FIRST       = 1'b1,
    parameter logic IDLE_LEVEL      = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              tx_out,
    output logic              tx_oe,
    output logic              busy,
    output logic              done
);

    localparam int c_MAX_BITS = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
    localparam int c_BIT_W    = $clog2(c_MAX_BITS + 1);
    localparam logic [c_BIT_W-1:0] c_LAST_DATA = c_BIT_W'(DATA_W - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_PRE  = c_BIT_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);

    tx_state_t           r_state;
    logic                r_mode;
    logic [DATA_W-1:0]   r_shreg;
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic                r_tx_out;
    logic                r_tx_oe;
    logic                r_done;

    logic                w_xfer;
    logic                w_run;
    logic                w_half_end;
    logic                w_phase;
    logic                w_cur_bit;
    logic                w_next_bit;
    logic                w_first_in;
    logic [DATA_W-1:0]   w_shifted;
    logic                w_level_bit;

    assign s_ready = (r_state == IDLE) & en;
    assign w_xfer  = s_valid & s_ready;
    assign w_run   = (r_state != IDLE) & en;
    assign busy    = (r_state != IDLE);
    assign tx_out  = r_tx_out;
    assign tx_oe   = r_tx_oe;
    assign done    = r_done;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted  = r_shreg << 1;
            assign w_cur_bit  = r_shreg[DATA_W-1];
            assign w_next_bit = w_shifted[DATA_W-1];
            assign w_first_in = s_data[DATA_W-1];
        end else begin : g_lsb_first
            assign w_shifted  = r_shreg >> 1;
            assign w_cur_bit  = r_shreg[0];
            assign w_next_bit = w_shifted[0];
            assign w_first_in = s_data[0];
        end
    endgenerate

    // Preamble bit k is 1 for even k, so the bit counter LSB selects it.
    assign w_level_bit = (r_state == PREAMBLE) ? ~r_bit_cnt[0] : w_cur_bit;

    manchester_half_timer #(
        .HALF_BIT_CYCLES (HALF_BIT_CYCLES)
    ) u_half_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (w_run),
        .clear    (~w_run),
        .half_end (w_half_end),
        .phase    (w_phase)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mode    <= MODE_IEEE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_tx_out  <= IDLE_LEVEL;
            r_tx_oe   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_mode    <= mode;
                        r_shreg   <= s_data;
                        r_bit_cnt <= '0;
                        r_tx_oe   <= 1'b1;
                        if (PREAMBLE_BITS > 0) begin
                            r_state  <= PREAMBLE;
                            r_tx_out <= manch_half(1'b1, mode, 1'b0);
                        end else begin
                            r_state  <= DATA;
                            r_tx_out <= manch_half(w_first_in, mode, 1'b0);
                        end
                    end
                end
                default: begin
                    if (!en) begin
                        r_state   <= IDLE;
                        r_tx_out  <= IDLE_LEVEL;
                        r_tx_oe   <= 1'b0;
                        r_bit_cnt <= '0;
                    end else if (w_half_end) begin
                        if (!w_phase) begin
                            r_tx_out <= manch_half(w_level_bit, r_mode, 1'b1);
                        end else if (r_state == PREAMBLE) begin
                            if (r_bit_cnt == c_LAST_PRE) begin
                                r_state   <= DATA;
                                r_bit_cnt <= '0;
                                r_tx_out  <= manch_half(w_cur_bit, r_mode, 1'b0);
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                                r_tx_out  <= manch_half(r_bit_cnt[0], r_mode, 1'b0);
                            end
                        end else begin
                            r_shreg <= w_shifted;
                            if (r_bit_cnt == c_LAST_DATA) begin
                                r_state   <= IDLE;
                                r_tx_out  <= IDLE_LEVEL;
                                r_tx_oe   <= 1'b0;
                                r_done    <= 1'b1;
                                r_bit_cnt <= '0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                                r_tx_out  <= manch_half(w_next_bit, r_mode, 1'b0);
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
